// File: rtl/ipd_secuenciador_if.sv
// Handshake and data bundle between the sampling/PWM side and the I-PD sequencer.
// The master drives the strobe, clear, setpoint, measurement and gains; the slave returns the command and status.
interface ipd_secuenciador_if #(
    parameter int N = 18
);
    logic                inicio;
    logic                limpiar;
    logic signed [N-1:0] r;
    logic signed [N-1:0] y;
    logic signed [N-1:0] kp;
    logic signed [N-1:0] ki;
    logic signed [N-1:0] kd;
    logic signed [N-1:0] u;
    logic                listo;
    logic                ocupado;
    logic                perdido;

    modport master (
        output inicio, limpiar, r, y, kp, ki, kd,
        input  u, listo, ocupado, perdido
    );

    modport slave (
        input  inicio, limpiar, r, y, kp, ki, kd,
        output u, listo, ocupado, perdido
    );
endinterface

// File: rtl/ipd_secuenciador.sv
// I-PD servo sequencer: u = I - P - D, with one signed multiplier time-shared over six states per sample.
// Every intermediate result is saturated to the N-bit signed range.
module ipd_secuenciador #(
    parameter int Magnitud = 17,
    parameter int Decimal  = 0
) (
    input logic               clk,
    input logic               reset,
    ipd_secuenciador_if.slave bus
);
    localparam int N = Magnitud + Decimal + 1;

    localparam logic signed [2*N-1:0] SAT_HI = {{(N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [2*N-1:0] SAT_LO = {{(N+1){1'b1}}, {(N-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        MUL_I,
        MUL_P,
        MUL_D,
        SUMA
    } state_t;

    state_t state, state_next;

    logic signed [N-1:0] r_c, y_c, kp_c, ki_c, kd_c;
    logic signed [N-1:0] e, dy, i_acc, p, d, y_prev, u;
    logic                listo, perdido;

    logic signed [N-1:0]   mul_a, mul_b, prod_sat;
    logic signed [2*N-1:0] prod, prod_sh;
    logic signed [N:0]     diff_e, diff_dy, i_sum;
    logic signed [N+1:0]   suma;

    function automatic logic signed [N-1:0] sat(input logic signed [2*N-1:0] x);
        if (x > SAT_HI) begin
            return SAT_HI[N-1:0];
        end else if (x < SAT_LO) begin
            return SAT_LO[N-1:0];
        end
        return x[N-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written in always_comb gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        mul_a      = kp_c;
        mul_b      = y_c;
        case (state)
            IDLE:    if (bus.inicio) state_next = ERR;
            ERR:     state_next = MUL_I;
            MUL_I: begin
                mul_a      = ki_c;
                mul_b      = e;
                state_next = MUL_P;
            end
            MUL_P:   state_next = MUL_D;
            MUL_D: begin
                mul_a      = kd_c;
                mul_b      = dy;
                state_next = SUMA;
            end
            SUMA:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Size casts sign-extend, so each sum has headroom before it is clamped back to N bits.
    assign prod     = (2*N)'(mul_a) * (2*N)'(mul_b);
    assign prod_sh  = prod >>> Decimal;
    assign prod_sat = sat(prod_sh);
    assign diff_e   = (N+1)'(r_c) - (N+1)'(y_c);
    assign diff_dy  = (N+1)'(y_c) - (N+1)'(y_prev);
    assign i_sum    = (N+1)'(i_acc) + (N+1)'(prod_sat);
    assign suma     = (N+2)'(i_acc) - (N+2)'(p) - (N+2)'(d);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_c     <= '0;
            y_c     <= '0;
            kp_c    <= '0;
            ki_c    <= '0;
            kd_c    <= '0;
            e       <= '0;
            dy      <= '0;
            i_acc   <= '0;
            p       <= '0;
            d       <= '0;
            y_prev  <= '0;
            u       <= '0;
            listo   <= 1'b0;
            perdido <= 1'b0;
        end else begin
            listo   <= 1'b0;
            perdido <= bus.inicio && (state != IDLE);
            case (state)
                IDLE: begin
                    if (bus.inicio) begin
                        r_c  <= bus.r;
                        y_c  <= bus.y;
                        kp_c <= bus.kp;
                        ki_c <= bus.ki;
                        kd_c <= bus.kd;
                    end
                end
                ERR: begin
                    e  <= sat((2*N)'(diff_e));
                    dy <= sat((2*N)'(diff_dy));
                end
                MUL_I: i_acc <= sat((2*N)'(i_sum));
                MUL_P: p     <= prod_sat;
                MUL_D: d     <= prod_sat;
                SUMA: begin
                    u      <= sat((2*N)'(suma));
                    y_prev <= y_c;
                    listo  <= 1'b1;
                end
                default: ;
            endcase
            // NOTE: the last non-blocking assignment in the block wins, so the clear overrides any update above.
            if (bus.limpiar) begin
                i_acc  <= '0;
                y_prev <= '0;
            end
        end
    end

    assign bus.u       = u;
    assign bus.listo   = listo;
    assign bus.ocupado = (state != IDLE);
    assign bus.perdido = perdido;
endmodule
